// File: rtl/dlsc_cpu1_decode.sv
// dlsc_cpu1_decode: registered decode stage of cpu1.
// Turns one 32-bit instruction word per cycle into ALU control and
// operand-select signals for the execute stage.
//
// Handshakes: a transfer on either side happens on a rising clock edge
// where valid and ready are both high. While out_valid is high and
// out_ready is low, every out_*/alu_* signal holds its value.
//
// A register scoreboard holds back an instruction when any register it
// names is still owed a writeback. That includes the op sitting in the
// output register, because that op has not yet reached the execute stage.
module dlsc_cpu1_decode #(
    parameter int SCOREBOARD  = 1,
    parameter int ILLEGAL_NOP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  out_ra,
    output logic [4:0]  out_rb,
    output logic [4:0]  out_rd,
    output logic        out_b_imm,
    output logic [31:0] out_imm,
    output logic        out_a_signed,
    output logic        out_b_signed,
    output logic [1:0]  alu_mode,
    output logic [1:0]  alu_add_op,
    output logic [1:0]  alu_logic_op,
    output logic        alu_add_signed,
    output logic        alu_logic_bypass,
    output logic        alu_shift_op,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr
);

    // Instruction fields
    logic [5:0]  f_op;
    logic [4:0]  f_rd;
    logic [4:0]  f_ra;
    logic [4:0]  f_rb;
    logic [15:0] f_imm;
    logic [3:0]  f_funct;

    assign f_op    = in_instr[31:26];
    assign f_rd    = in_instr[25:21];
    assign f_ra    = in_instr[20:16];
    assign f_rb    = in_instr[15:11];
    assign f_imm   = in_instr[15:0];
    assign f_funct = in_instr[3:0];

    // Decoded (not yet registered) values
    logic [4:0]  d_ra;
    logic [4:0]  d_rb;
    logic [4:0]  d_rd;
    logic        d_b_imm;
    logic [31:0] d_imm;
    logic        d_a_signed;
    logic        d_b_signed;
    logic [1:0]  d_mode;
    logic [1:0]  d_add_op;
    logic [1:0]  d_logic_op;
    logic        d_add_signed;
    logic        d_logic_bypass;
    logic        d_shift_op;
    logic        d_illegal;

    logic hazard;
    logic accept;
    logic issue;

    // Combinational decode of the incoming word. I-type and illegal ops
    // report rb=0 (and illegal ops ra=rd=0), so they never match a pending bit.
    always_comb begin
        d_ra           = f_ra;
        d_rb           = f_rb;
        d_rd           = f_rd;
        d_b_imm        = 1'b0;
        d_imm          = 32'h0;
        d_a_signed     = 1'b0;
        d_b_signed     = 1'b0;
        d_mode         = 2'b00;
        d_add_op       = 2'b00;
        d_logic_op     = 2'b00;
        d_add_signed   = 1'b0;
        d_logic_bypass = 1'b0;
        d_shift_op     = 1'b0;
        d_illegal      = 1'b0;
        case (f_op)
            6'h00: begin
                case (f_funct)
                    4'd0: begin
                        d_a_signed   = 1'b1;
                        d_b_signed   = 1'b1;
                        d_add_signed = 1'b1;
                    end
                    4'd1: begin
                        d_add_op     = 2'b01;
                        d_a_signed   = 1'b1;
                        d_b_signed   = 1'b1;
                        d_add_signed = 1'b1;
                    end
                    4'd2: begin
                        d_mode   = 2'b01;
                        d_add_op = 2'b10;
                    end
                    4'd3: begin
                        d_mode   = 2'b01;
                        d_add_op = 2'b11;
                    end
                    4'd4: begin
                        d_mode     = 2'b01;
                        d_add_op   = 2'b01;
                        d_a_signed = 1'b1;
                        d_b_signed = 1'b1;
                    end
                    4'd5: begin
                        // both sign bits forced 0: 33-bit unsigned compare
                        d_mode   = 2'b01;
                        d_add_op = 2'b01;
                    end
                    4'd8, 4'd9, 4'd10, 4'd11: begin
                        d_mode     = 2'b11;
                        d_logic_op = f_funct[1:0];
                    end
                    4'd12: begin
                        d_mode = 2'b10;
                    end
                    4'd13: begin
                        d_mode     = 2'b10;
                        d_shift_op = 1'b1;
                    end
                    4'd14: begin
                        d_mode     = 2'b10;
                        d_shift_op = 1'b1;
                        d_a_signed = 1'b1;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            6'h01: begin
                d_rb         = 5'd0;
                d_b_imm      = 1'b1;
                d_imm        = {{16{f_imm[15]}}, f_imm};
                d_a_signed   = 1'b1;
                d_b_signed   = 1'b1;
                d_add_signed = 1'b1;
            end
            6'h02: begin
                d_rb       = 5'd0;
                d_b_imm    = 1'b1;
                d_imm      = {{16{f_imm[15]}}, f_imm};
                d_mode     = 2'b01;
                d_add_op   = 2'b01;
                d_a_signed = 1'b1;
                d_b_signed = 1'b1;
            end
            6'h03, 6'h04, 6'h05: begin
                d_rb       = 5'd0;
                d_b_imm    = 1'b1;
                d_imm      = {16'h0, f_imm};
                d_mode     = 2'b11;
                d_logic_op = (f_op == 6'h03) ? 2'b00 :
                             (f_op == 6'h04) ? 2'b01 : 2'b10;
            end
            6'h06: begin
                d_rb           = 5'd0;
                d_b_imm        = 1'b1;
                d_imm          = {f_imm, 16'h0};
                d_mode         = 2'b11;
                d_logic_bypass = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_ra = 5'd0;
            d_rb = 5'd0;
            d_rd = 5'd0;
        end
    end

    assign accept   = in_valid & in_ready;
    assign issue    = out_valid & out_ready;
    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;

    generate
        if (SCOREBOARD != 0) begin : g_sb
            logic [31:0] pending;
            logic [31:0] pending_nxt;
            logic [31:0] owed;

            // Registers still owed a writeback: retired-pending plus the held op's rd.
            always_comb begin
                owed = pending;
                if (out_valid && (out_rd != 5'd0)) begin
                    owed[out_rd] = 1'b1;
                end
            end

            assign hazard = owed[d_ra] | owed[d_rb] | owed[d_rd];

            // Writeback clears, issue sets; the set is applied last so it wins.
            always_comb begin
                pending_nxt = pending;
                if (wb_valid) begin
                    pending_nxt[wb_addr] = 1'b0;
                end
                if (issue && (out_rd != 5'd0)) begin
                    pending_nxt[out_rd] = 1'b1;
                end
                pending_nxt[0] = 1'b0;
            end

            // Scoreboard register; flush leaves it alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending <= 32'h0;
                end else begin
                    pending <= pending_nxt;
                end
            end
        end else begin : g_no_sb
            assign hazard = 1'b0;
        end
    endgenerate

    // Output register: load on accept, drop on issue or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_ra           <= 5'd0;
            out_rb           <= 5'd0;
            out_rd           <= 5'd0;
            out_b_imm        <= 1'b0;
            out_imm          <= 32'h0;
            out_a_signed     <= 1'b0;
            out_b_signed     <= 1'b0;
            alu_mode         <= 2'b00;
            alu_add_op       <= 2'b00;
            alu_logic_op     <= 2'b00;
            alu_add_signed   <= 1'b0;
            alu_logic_bypass <= 1'b0;
            alu_shift_op     <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= ~d_illegal | (ILLEGAL_NOP != 0);
            out_ra           <= d_ra;
            out_rb           <= d_rb;
            out_rd           <= d_rd;
            out_b_imm        <= d_b_imm;
            out_imm          <= d_imm;
            out_a_signed     <= d_a_signed;
            out_b_signed     <= d_b_signed;
            alu_mode         <= d_mode;
            alu_add_op       <= d_add_op;
            alu_logic_op     <= d_logic_op;
            alu_add_signed   <= d_add_signed;
            alu_logic_bypass <= d_logic_bypass;
            alu_shift_op     <= d_shift_op;
            out_illegal      <= d_illegal;
        end else if (issue) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dlsc_cpu1_decode.sv
// Testbench for dlsc_cpu1_decode: directed cases followed by random traffic,
// all compared cycle by cycle against a table-driven reference model.
module tb_dlsc_cpu1_decode;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [4:0]  out_ra, out_rb, out_rd;
    logic        out_b_imm;
    logic [31:0] out_imm;
    logic        out_a_signed, out_b_signed;
    logic [1:0]  alu_mode, alu_add_op, alu_logic_op;
    logic        alu_add_signed, alu_logic_bypass, alu_shift_op;
    logic        out_illegal;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = 5'd0;

    always #5 clk = ~clk;

    dlsc_cpu1_decode dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_ra(out_ra), .out_rb(out_rb), .out_rd(out_rd),
        .out_b_imm(out_b_imm), .out_imm(out_imm),
        .out_a_signed(out_a_signed), .out_b_signed(out_b_signed),
        .alu_mode(alu_mode), .alu_add_op(alu_add_op), .alu_logic_op(alu_logic_op),
        .alu_add_signed(alu_add_signed), .alu_logic_bypass(alu_logic_bypass),
        .alu_shift_op(alu_shift_op), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        b_imm;
        logic [31:0] imm;
        logic        a_signed;
        logic        b_signed;
        logic [1:0]  mode;
        logic [1:0]  add_op;
        logic [1:0]  logic_op;
        logic        add_signed;
        logic        logic_bypass;
        logic        shift_op;
        logic        illegal;
    } dec_t;

    // imm_kind: 0 none, 1 sign-extend, 2 zero-extend, 3 upper half
    typedef struct {
        bit       legal;
        bit [1:0] mode;
        bit [1:0] add_op;
        bit [1:0] logic_op;
        bit       a_s;
        bit       b_s;
        bit       add_s;
        bit       shift;
        bit       bypass;
        int       imm_kind;
    } row_t;

    row_t r_tab[16];
    row_t i_tab[64];

    dec_t dut_dec;
    assign dut_dec = {out_ra, out_rb, out_rd, out_b_imm, out_imm, out_a_signed,
                      out_b_signed, alu_mode, alu_add_op, alu_logic_op,
                      alu_add_signed, alu_logic_bypass, alu_shift_op, out_illegal};

    logic [59:0] exp_q[$];      // op expected in the output register (depth 0 or 1)
    logic [4:0]  inflight[$];   // destinations issued and not yet written back
    bit          m_pend[32];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic row_t mk(bit legal, bit [1:0] mode, bit [1:0] add_op, bit [1:0] lop,
                                bit a_s, bit b_s, bit add_s, bit shift, bit bypass, int ik);
        row_t r;
        r.legal = legal; r.mode = mode; r.add_op = add_op; r.logic_op = lop;
        r.a_s = a_s; r.b_s = b_s; r.add_s = add_s; r.shift = shift;
        r.bypass = bypass; r.imm_kind = ik;
        return r;
    endfunction

    task automatic init_tables();
        for (int i = 0; i < 16; i++) r_tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) i_tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //                 legal mode add lop a  b  adds sh byp imm
        r_tab[0]  = mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);   // ADD
        r_tab[1]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);   // SUB
        r_tab[2]  = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);   // SEQ
        r_tab[3]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);   // SNE
        r_tab[4]  = mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 0);   // SLT
        r_tab[5]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);   // SLTU
        r_tab[8]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);   // AND
        r_tab[9]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);   // OR
        r_tab[10] = mk(1, 3, 0, 2, 0, 0, 0, 0, 0, 0);   // XOR
        r_tab[11] = mk(1, 3, 0, 3, 0, 0, 0, 0, 0, 0);   // NOR
        r_tab[12] = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);   // SLL
        r_tab[13] = mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 0);   // SRL
        r_tab[14] = mk(1, 2, 0, 0, 1, 0, 0, 1, 0, 0);   // SRA
        i_tab[1]  = mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);   // ADDI
        i_tab[2]  = mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 1);   // SLTI
        i_tab[3]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 2);   // ANDI
        i_tab[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 2);   // ORI
        i_tab[5]  = mk(1, 3, 0, 2, 0, 0, 0, 0, 0, 2);   // XORI
        i_tab[6]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 3);   // LUI
    endtask

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        row_t rw;
        int   op;
        int   v;
        op = int'(w[31:26]);
        rw = (op == 0) ? r_tab[w[3:0]] : i_tab[op];
        d = '0;
        if (!rw.legal) begin
            d.illegal = 1'b1;
            return d;
        end
        d.rd = w[25:21];
        d.ra = w[20:16];
        d.rb = (op == 0) ? w[15:11] : 5'd0;
        d.b_imm = (op != 0);
        v = int'(w[15:0]);
        case (rw.imm_kind)
            1: d.imm = 32'((v >= 32768) ? v - 65536 : v);
            2: d.imm = 32'(v);
            3: d.imm = 32'(v * 65536);
            default: d.imm = 32'h0;
        endcase
        d.a_signed = rw.a_s; d.b_signed = rw.b_s;
        d.mode = rw.mode; d.add_op = rw.add_op; d.logic_op = rw.logic_op;
        d.add_signed = rw.add_s; d.logic_bypass = rw.bypass; d.shift_op = rw.shift;
        return d;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver: one cycle ----------------
    // Drive inputs at the falling edge, compare the DUT against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic wbv, input logic [4:0] wba, input logic fl);
        dec_t d;
        dec_t held;
        bit   owed[32];
        bit   held_v;
        bit   exp_rdy;
        bit   issue;
        @(negedge clk);
        in_valid = iv; in_instr = ins; out_ready = ordy;
        wb_valid = wbv; wb_addr = wba; flush = fl;
        #1;
        d = ref_decode(ins);
        held_v = (exp_q.size() != 0);
        held = held_v ? dec_t'(exp_q[0]) : dec_t'('0);
        owed = m_pend;
        if (held_v && held.rd != 5'd0) owed[held.rd] = 1'b1;
        owed[0] = 1'b0;
        exp_rdy = (!held_v || ordy) && !(owed[d.ra] || owed[d.rb] || owed[d.rd]) && !fl;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(held_v));
        if (held_v) check("out_fields", 64'(dut_dec), 64'(held));

        issue = held_v && ordy;
        if (wbv) begin
            m_pend[wba] = 1'b0;
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i] == wba) begin
                    inflight.delete(i);
                    break;
                end
            end
        end
        if (issue && held.rd != 5'd0) begin
            m_pend[held.rd] = 1'b1;
            inflight.push_back(held.rd);
        end
        m_pend[0] = 1'b0;
        if (fl) exp_q.delete();
        else if (iv && exp_rdy) begin
            exp_q.delete();
            exp_q.push_back(d);
        end else if (issue) exp_q.delete();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, ordy, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic retire(input logic [4:0] r);
        step(1'b0, 32'h0, 1'b1, 1'b1, r, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = 5'd0; flush = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outs", 64'(dut_dec), 64'(0));
        exp_q.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 4) op = 6'h00;
        else if (sel < 9) op = 6'($urandom_range(1, 6));
        else op = 6'($urandom_range(7, 63));
        if (op == 6'h00)
            return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 7'($urandom), 4'($urandom_range(0, 15))};
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    // ---------------- stimulus ----------------
    localparam logic [31:0] ADD_R3  = 32'h00611000;  // ADD r3,r1,r2
    localparam logic [31:0] ADD_R5  = 32'h00A31800;  // ADD r5,r3,r3
    localparam logic [31:0] SLTI_R4 = 32'h0885FFFF;  // SLTI r4,r5,-1
    localparam logic [31:0] LUI_R7  = 32'h18E01234;  // LUI r7,0x1234
    localparam logic [31:0] ORI_R2  = 32'h104100F0;  // ORI r2,r1,0xF0
    localparam logic [31:0] XORI_R6 = 32'h14C00055;  // XORI r6,r0,0x55
    localparam logic [31:0] ILL_OP  = 32'hFD200000;  // op 0x3F, rd field 9
    localparam logic [31:0] ADD_R10 = 32'h01494800;  // ADD r10,r9,r9
    localparam logic [31:0] SUB_R8  = 32'h01011001;  // SUB r8,r1,r2
    localparam logic [31:0] ADD_R11 = 32'h01684000;  // ADD r11,r8,r8

    initial begin
        dec_t snap;
        init_tables();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        do_reset();

        // ADD r3 then dependent ADD r5,r3,r3
        step(1, ADD_R3, 1, 0, 0, 0);
        check("add_in_ready", 64'(in_ready), 64'(1));
        step(1, ADD_R5, 1, 0, 0, 0);
        check("add_rd", 64'(out_rd), 64'(3));
        check("add_ra", 64'(out_ra), 64'(1));
        check("add_rb", 64'(out_rb), 64'(2));
        check("add_mode", 64'({alu_mode, alu_add_op, out_b_imm}), 64'(0));
        check("raw_stall", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) step(1, ADD_R5, 1, 0, 0, 0);
        step(1, ADD_R5, 1, 1, 5'd3, 0);
        check("no_wb_bypass", 64'(in_ready), 64'(0));
        step(1, ADD_R5, 1, 0, 0, 0);
        check("stall_release", 64'(in_ready), 64'(1));
        idle(1);
        check("add5_rd", 64'(out_rd), 64'(5));
        retire(5);

        // SLTI r4,r5,-1
        step(1, SLTI_R4, 1, 0, 0, 0);
        idle(1);
        check("slti_imm", 64'(out_imm), 64'(32'hFFFFFFFF));
        check("slti_ctl", 64'({alu_mode, alu_add_op, out_b_imm, out_a_signed, out_b_signed}),
              64'(7'b01_01_1_1_1));
        retire(4);

        // LUI r7,0x1234
        step(1, LUI_R7, 1, 0, 0, 0);
        idle(1);
        check("lui_imm", 64'(out_imm), 64'(32'h12340000));
        check("lui_ctl", 64'({alu_mode, alu_logic_bypass}), 64'(3'b11_1));
        retire(7);

        // Output held for 5 cycles of back-pressure
        step(1, ORI_R2, 0, 0, 0, 0);
        snap = dut_dec;
        for (int i = 0; i < 5; i++) begin
            step(1, XORI_R6, 0, 0, 0, 0);
            if (i == 0) snap = dut_dec;
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_stable", 64'(dut_dec), 64'(snap));
        end
        check("hold_imm", 64'(out_imm), 64'(32'hF0));
        step(1, XORI_R6, 1, 0, 0, 0);
        check("hold_release", 64'(in_ready), 64'(1));
        idle(1);
        check("xori_rd", 64'(out_rd), 64'(6));
        check("xori_imm", 64'(out_imm), 64'(32'h55));
        retire(2);
        retire(6);

        // Illegal op issues as NOP and sets no pending bit
        step(1, ILL_OP, 1, 0, 0, 0);
        check("ill_accept", 64'(in_ready), 64'(1));
        step(1, ADD_R10, 1, 0, 0, 0);
        check("ill_flag", 64'(out_illegal), 64'(1));
        check("ill_rd", 64'(out_rd), 64'(0));
        check("ill_no_pend", 64'(in_ready), 64'(1));
        idle(1);
        retire(10);

        // Flush drops the held op without touching the scoreboard
        step(1, SUB_R8, 0, 0, 0, 0);
        step(1, XORI_R6, 0, 0, 0, 1);
        check("flush_ready", 64'(in_ready), 64'(0));
        idle(0);
        check("flush_drop", 64'(out_valid), 64'(0));
        step(1, ADD_R11, 1, 0, 0, 0);
        check("flush_no_pend", 64'(in_ready), 64'(1));
        idle(1);
        retire(11);

        // Reset in the middle of a stall
        step(1, ADD_R3, 1, 0, 0, 0);
        step(1, ADD_R5, 1, 0, 0, 0);
        step(1, ADD_R5, 1, 0, 0, 0);
        do_reset();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            logic       iv, ordy, wbv, fl;
            logic [4:0] wba;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            wbv  = 1'b0;
            wba  = 5'($urandom_range(0, 31));
            if (inflight.size() != 0 && $urandom_range(0, 2) == 0) begin
                wbv = 1'b1;
                wba = inflight[$urandom_range(0, inflight.size() - 1)];
            end
            step(iv, rand_instr(), ordy, wbv, wba, fl);
        end
        for (int c = 0; c < 12; c++) begin
            if (inflight.size() != 0) retire(inflight[0]);
            else idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
